fetch_decode_execute: RTL and testbench
=======================================

// Module: fetch_decode_execute
// PURPOSE
// - Front end of the 5-stage pipeline: IF (PC + imem request), ID (field split, register read), EX (ALU, jump resolve).
// - Feeds memory_unit/write_back downstream; register file values arrive from the writeback stage as inputs.
// - Jump redirect and flush are closed internally.
// PARAMETERS
// - PC_W 8: PC, jump address and imem address width.
// - IW 20: instruction width.
// - DW 16: data and register width.
// PORTS
// - clkwire in 1: single clock; all state updates on posedge.
// - rst_n in 1: asynchronous, active-low reset.
// - imem_addr out 8: current PC.
// - imem_data in 20: instruction at imem_addr, combinational.
// - regwire1..regwire8 in 16 each: architectural registers R0..R7.
// - instruction out 4: EX-stage opcode.
// - ALU_output out 16: EX result.
// - regdest out 4: EX destination register field.
// - ldst out 4: EX memory line number for LOAD/STORE.
// - jump_address out 8: EX jump target.
// - jump_selector out 1: EX jump taken.
// - halted out 1: HALT has been decoded.
// BEHAVIOUR
// - Instruction format:
//   - [19:16] op, [15:12] rd, [11:8] rs1, [7:4] rs2.
//   - [7:0] imm8, zero-extended to 16 bits.
//   - [3:0] mem line.
// - Register select: field 0-7 selects regwire1-regwire8; field 8-15 reads 0.
// - Opcodes and EX result:
//   - 0000 NOP: result 0.
//   - 0001 ADD: rs1+rs2.
//   - 0010 SUB: rs1-rs2.
//   - 0011 AND.
//   - 0100 OR.
//   - 0101 XOR.
//   - 0110 ADDI: rs1+imm.
//   - 0111 SHL: rs1<<rs2[3:0].
//   - 1000 SHR: logical shift, rs1>>rs2[3:0].
//   - 1001 LOAD: result 0; ldst=line.
//   - 1010 STORE: result = rs1 data; ldst=line.
//   - 1011 JMP: taken, target=imm.
//   - 1100 BEQ: taken iff rs1==rs2; target=imm.
//   - 1101 MOVI: result=imm.
//   - 1110 HALT.
//   - 1111: treated as NOP.
// - Arithmetic is modulo 2^16 with no flags; overflow wraps.
// - Pipeline registers:
//   - IF/ID: instruction.
//   - ID/EX: op, rd, line, op1, op2, imm.
//   - EX outputs are registered.
//   - Latency: an instruction fetched at PC=n appears on EX outputs 3 rising edges after the PC shows n.
// - PC update: PC increments by 1 each cycle, wrapping 255 -> 0.
// - Jump:
//   - When EX asserts jump_selector, PC <= jump_address on the next edge.
//   - IF/ID and ID/EX are loaded with NOP on the same edge, so the 2 younger instructions are squashed.
//   - jump_selector is high for exactly one cycle per taken jump.
// - HALT:
//   - When HALT is in ID, halted is set (sticky) and PC freezes.
//   - IF/ID then receives NOP every cycle.
//   - Instructions already in ID/EX still complete.
//   - A jump taken in EX on the same edge has priority over the freeze; halted is still set.
// - No hazard detection or forwarding. The ID stage samples regwire* combinationally; software inserts NOPs between dependent instructions.
// - Reset (async, rst_n=0):
//   - PC=0, halted=0.
//   - Both pipeline registers hold NOP.
//   - All EX outputs are 0.
//   - Reset asserted mid-jump or mid-halt aborts fully; fetch restarts at 0 after release.
// - Non-memory ops drive ldst=0. regdest passes rd for every op.
// STRUCTURE
// - Shared package fde_pkg holds:
//   - opcode localparams (OP_NOP..OP_HALT);
//   - NOP_INSTR = 20'h0;
//   - field-slice constants.
// - One natural sub-module: fde_alu, a combinational opcode-to-result plus jump-decision unit.
// - IF, ID and the EX register stay in the top module.
// TESTING
// - Shared setup: regs R0..R7 = 5,6,7,8,9,10,11,12.
// - ADD: 20'h10120 (R0=R1+R2) -> 3 edges later ALU_output=13, regdest=0, instruction=0001.
// - SUB and wrap:
//   - 20'h20210 -> ALU_output=16'd1 (7-6).
//   - 20'h20120 -> 16'hFFFF.
// - LOAD: 20'h93000 with line 5 (20'h93005) -> instruction=1001, ldst=5, regdest=3.
// - JMP:
//   - 20'hB0040 at PC 2 -> jump_selector=1 with jump_address=8'h40 for one cycle.
//   - The 2 following instructions appear as NOP.
//   - imem_addr becomes 0x40.
// - BEQ:
//   - 20'hC0110 (R1==R1) is taken.
//   - 20'hC0120 is not taken; PC keeps incrementing.
// - HALT: 20'hE0000 -> halted=1 and imem_addr frozen. Asserting rst_n=0 mid-run restores PC=0 and all outputs 0.

Source files
------------

// File: rtl/fde_pkg.sv
// Shared definitions for the fetch/decode/execute front end.
// Holds the opcode encodings, the NOP instruction word, the bit positions
// of every instruction field, and a small opcode classification helper.
package fde_pkg;

    // Opcode encodings (instruction bits [19:16]).
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_ADDI  = 4'h6;
    localparam logic [3:0] OP_SHL   = 4'h7;
    localparam logic [3:0] OP_SHR   = 4'h8;
    localparam logic [3:0] OP_LOAD  = 4'h9;
    localparam logic [3:0] OP_STORE = 4'hA;
    localparam logic [3:0] OP_JMP   = 4'hB;
    localparam logic [3:0] OP_BEQ   = 4'hC;
    localparam logic [3:0] OP_MOVI  = 4'hD;
    localparam logic [3:0] OP_HALT  = 4'hE;

    localparam logic [19:0] NOP_INSTR = 20'h0;

    // Instruction field positions. imm8 overlaps rs2 and the memory line.
    localparam int OP_HI   = 19;
    localparam int OP_LO   = 16;
    localparam int RD_HI   = 15;
    localparam int RD_LO   = 12;
    localparam int RS1_HI  = 11;
    localparam int RS1_LO  = 8;
    localparam int RS2_HI  = 7;
    localparam int RS2_LO  = 4;
    localparam int IMM_HI  = 7;
    localparam int IMM_LO  = 0;
    localparam int LINE_HI = 3;
    localparam int LINE_LO = 0;

    // LOAD and STORE are the only ops that carry a memory line downstream.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/fde_alu.sv
// Combinational execute unit: maps opcode + operands to a result and
// decides whether a jump is taken.
// Ports:
//   op_i     - opcode from the ID/EX register
//   op1_i    - rs1 operand
//   op2_i    - rs2 operand
//   imm_i    - zero-extended imm8
//   result_o - ALU result (modulo 2^DW, no flags)
//   jump_o   - jump taken (JMP always, BEQ when operands are equal)
module fde_alu
    import fde_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [3:0]    op_i,
    input  logic [DW-1:0] op1_i,
    input  logic [DW-1:0] op2_i,
    input  logic [DW-1:0] imm_i,
    output logic [DW-1:0] result_o,
    output logic          jump_o
);

    always_comb begin
        result_o = '0;
        jump_o   = 1'b0;
        case (op_i)
            OP_ADD:   result_o = op1_i + op2_i;
            OP_SUB:   result_o = op1_i - op2_i;
            OP_AND:   result_o = op1_i & op2_i;
            OP_OR:    result_o = op1_i | op2_i;
            OP_XOR:   result_o = op1_i ^ op2_i;
            OP_ADDI:  result_o = op1_i + imm_i;
            OP_SHL:   result_o = op1_i << op2_i[3:0];
            OP_SHR:   result_o = op1_i >> op2_i[3:0];
            OP_STORE: result_o = op1_i;
            OP_MOVI:  result_o = imm_i;
            OP_JMP:   jump_o   = 1'b1;
            OP_BEQ:   jump_o   = (op1_i == op2_i);
            // NOP, LOAD, HALT and the unused 4'hF all produce 0.
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/fetch_decode_execute.sv
// Front end of the 5-stage pipeline: IF (PC, imem request), ID (field
// split, register read) and EX (ALU, jump resolve, registered outputs).
// Ports:
//   clkwire       - clock, all state on posedge
//   rst_n         - asynchronous active-low reset
//   imem_addr     - current PC
//   imem_data     - instruction at imem_addr (combinational)
//   regwire1..8   - architectural registers R0..R7 from writeback
//   instruction   - EX opcode
//   ALU_output    - EX result
//   regdest       - EX destination register field
//   ldst          - EX memory line (LOAD/STORE only, else 0)
//   jump_address  - EX jump target (JMP/BEQ, else 0)
//   jump_selector - EX jump taken, one cycle per taken jump
//   halted        - sticky, set when HALT reaches ID
module fetch_decode_execute
    import fde_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int IW   = 20,
    parameter int DW   = 16
) (
    input  logic            clkwire,
    input  logic            rst_n,
    output logic [PC_W-1:0] imem_addr,
    input  logic [IW-1:0]   imem_data,
    input  logic [DW-1:0]   regwire1,
    input  logic [DW-1:0]   regwire2,
    input  logic [DW-1:0]   regwire3,
    input  logic [DW-1:0]   regwire4,
    input  logic [DW-1:0]   regwire5,
    input  logic [DW-1:0]   regwire6,
    input  logic [DW-1:0]   regwire7,
    input  logic [DW-1:0]   regwire8,
    output logic [3:0]      instruction,
    output logic [DW-1:0]   ALU_output,
    output logic [3:0]      regdest,
    output logic [3:0]      ldst,
    output logic [PC_W-1:0] jump_address,
    output logic            jump_selector,
    output logic            halted
);

    // IF state
    logic [PC_W-1:0] pc_q, pc_d;
    logic            halted_q, halted_d;

    // IF/ID register
    logic [IW-1:0]   ifid_q, ifid_d;

    // ID/EX register
    logic [3:0]      idex_op_q, idex_op_d;
    logic [3:0]      idex_rd_q, idex_rd_d;
    logic [3:0]      idex_line_q, idex_line_d;
    logic [DW-1:0]   idex_op1_q, idex_op1_d;
    logic [DW-1:0]   idex_op2_q, idex_op2_d;
    logic [DW-1:0]   idex_imm_q, idex_imm_d;

    // EX output register
    logic [3:0]      ex_instr_q, ex_instr_d;
    logic [DW-1:0]   ex_alu_q, ex_alu_d;
    logic [3:0]      ex_rd_q, ex_rd_d;
    logic [3:0]      ex_ldst_q, ex_ldst_d;
    logic [PC_W-1:0] ex_jaddr_q, ex_jaddr_d;
    logic            ex_jsel_q, ex_jsel_d;

    // ID decode
    logic [DW-1:0]   regs [8];
    logic [3:0]      id_op, id_rs1, id_rs2;
    logic            id_halt;

    // EX combinational
    logic [DW-1:0]   alu_result;
    logic            alu_jump;
    logic [PC_W-1:0] ex_target;

    assign regs[0] = regwire1;
    assign regs[1] = regwire2;
    assign regs[2] = regwire3;
    assign regs[3] = regwire4;
    assign regs[4] = regwire5;
    assign regs[5] = regwire6;
    assign regs[6] = regwire7;
    assign regs[7] = regwire8;

    assign id_op   = ifid_q[OP_HI:OP_LO];
    assign id_rs1  = ifid_q[RS1_HI:RS1_LO];
    assign id_rs2  = ifid_q[RS2_HI:RS2_LO];
    assign id_halt = (id_op == OP_HALT);

    fde_alu #(.DW(DW)) u_alu (
        .op_i     (idex_op_q),
        .op1_i    (idex_op1_q),
        .op2_i    (idex_op2_q),
        .imm_i    (idex_imm_q),
        .result_o (alu_result),
        .jump_o   (alu_jump)
    );

    assign ex_target = idex_imm_q[PC_W-1:0];

    always_comb begin
        // Default: free-running fetch and normal pipeline advance.
        pc_d        = pc_q + PC_W'(1);
        halted_d    = halted_q;
        ifid_d      = imem_data;
        idex_op_d   = id_op;
        idex_rd_d   = ifid_q[RD_HI:RD_LO];
        idex_line_d = ifid_q[LINE_HI:LINE_LO];
        // Register fields 8..15 name no register and read as 0.
        idex_op1_d  = id_rs1[3] ? '0 : regs[id_rs1[2:0]];
        idex_op2_d  = id_rs2[3] ? '0 : regs[id_rs2[2:0]];
        idex_imm_d  = {{(DW-8){1'b0}}, ifid_q[IMM_HI:IMM_LO]};

        ex_instr_d  = idex_op_q;
        ex_alu_d    = alu_result;
        ex_rd_d     = idex_rd_q;
        ex_ldst_d   = is_mem_op(idex_op_q) ? idex_line_q : 4'd0;
        ex_jaddr_d  = ((idex_op_q == OP_JMP) || (idex_op_q == OP_BEQ)) ? ex_target : '0;
        ex_jsel_d   = alu_jump;

        // HALT in ID: freeze PC and starve IF/ID; HALT itself moves on to EX.
        if (id_halt) begin
            halted_d = 1'b1;
        end
        if (halted_q || id_halt) begin
            pc_d   = pc_q;
            ifid_d = NOP_INSTR;
        end

        // The jump is resolved from the ID/EX contents, so the redirect lands
        // on the same edge that registers jump_selector. The two instructions
        // behind it (in IF/ID and being fetched) are replaced by NOPs, and the
        // redirect wins over a simultaneous HALT freeze.
        if (alu_jump) begin
            pc_d        = ex_target;
            ifid_d      = NOP_INSTR;
            idex_op_d   = OP_NOP;
            idex_rd_d   = '0;
            idex_line_d = '0;
            idex_op1_d  = '0;
            idex_op2_d  = '0;
            idex_imm_d  = '0;
        end
    end

    always_ff @(posedge clkwire or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= '0;
            halted_q    <= 1'b0;
            ifid_q      <= NOP_INSTR;
            idex_op_q   <= OP_NOP;
            idex_rd_q   <= '0;
            idex_line_q <= '0;
            idex_op1_q  <= '0;
            idex_op2_q  <= '0;
            idex_imm_q  <= '0;
            ex_instr_q  <= '0;
            ex_alu_q    <= '0;
            ex_rd_q     <= '0;
            ex_ldst_q   <= '0;
            ex_jaddr_q  <= '0;
            ex_jsel_q   <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            halted_q    <= halted_d;
            ifid_q      <= ifid_d;
            idex_op_q   <= idex_op_d;
            idex_rd_q   <= idex_rd_d;
            idex_line_q <= idex_line_d;
            idex_op1_q  <= idex_op1_d;
            idex_op2_q  <= idex_op2_d;
            idex_imm_q  <= idex_imm_d;
            ex_instr_q  <= ex_instr_d;
            ex_alu_q    <= ex_alu_d;
            ex_rd_q     <= ex_rd_d;
            ex_ldst_q   <= ex_ldst_d;
            ex_jaddr_q  <= ex_jaddr_d;
            ex_jsel_q   <= ex_jsel_d;
        end
    end

    assign imem_addr     = pc_q;
    assign halted        = halted_q;
    assign instruction   = ex_instr_q;
    assign ALU_output    = ex_alu_q;
    assign regdest       = ex_rd_q;
    assign ldst          = ex_ldst_q;
    assign jump_address  = ex_jaddr_q;
    assign jump_selector = ex_jsel_q;

endmodule

// File: tb/tb_fetch_decode_execute.sv
module tb_fetch_decode_execute;

    logic        clkwire;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [19:0] imem_data;
    logic [15:0] regwire1, regwire2, regwire3, regwire4;
    logic [15:0] regwire5, regwire6, regwire7, regwire8;
    logic [3:0]  instruction;
    logic [15:0] ALU_output;
    logic [3:0]  regdest;
    logic [3:0]  ldst;
    logic [7:0]  jump_address;
    logic        jump_selector;
    logic        halted;

    logic [19:0] imem [256];

    int checks   = 0;
    int failures = 0;

    fetch_decode_execute #(.PC_W(8), .IW(20), .DW(16)) dut (
        .clkwire       (clkwire),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .regwire1      (regwire1),
        .regwire2      (regwire2),
        .regwire3      (regwire3),
        .regwire4      (regwire4),
        .regwire5      (regwire5),
        .regwire6      (regwire6),
        .regwire7      (regwire7),
        .regwire8      (regwire8),
        .instruction   (instruction),
        .ALU_output    (ALU_output),
        .regdest       (regdest),
        .ldst          (ldst),
        .jump_address  (jump_address),
        .jump_selector (jump_selector),
        .halted        (halted)
    );

    assign imem_data = imem[imem_addr];

    initial clkwire = 1'b0;
    always #5 clkwire = ~clkwire;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clkwire);
        #1;
    endtask

    task automatic check_ex(input string tag, input logic [3:0] ins, input logic [15:0] alu,
                            input logic [3:0] rd, input logic [3:0] ls, input logic js);
        check({tag, ".instruction"}, {28'd0, instruction}, {28'd0, ins});
        check({tag, ".ALU_output"}, {16'd0, ALU_output}, {16'd0, alu});
        check({tag, ".regdest"}, {28'd0, regdest}, {28'd0, rd});
        check({tag, ".ldst"}, {28'd0, ldst}, {28'd0, ls});
        check({tag, ".jump_selector"}, {31'd0, jump_selector}, {31'd0, js});
    endtask

    initial begin
        rst_n = 1'b0;
        regwire1 = 16'd5;  regwire2 = 16'd6;  regwire3 = 16'd7;  regwire4 = 16'd8;
        regwire5 = 16'd9;  regwire6 = 16'd10; regwire7 = 16'd11; regwire8 = 16'd12;

        for (int i = 0; i < 256; i++) imem[i] = 20'h0;
        imem[0]    = 20'h10120; // ADD  R0 = R1+R2         -> 13
        imem[1]    = 20'h20210; // SUB  R0 = R2-R1         -> 1
        imem[2]    = 20'h20120; // SUB  R0 = R1-R2         -> FFFF
        imem[3]    = 20'h93005; // LOAD R3, line 5
        imem[4]    = 20'hC0120; // BEQ  R1,R2 not taken
        imem[5]    = 20'h641FF; // ADDI R4 = R1+FF         -> 105
        imem[6]    = 20'h75320; // SHL  R5 = R3<<R2        -> 400
        imem[7]    = 20'h86790; // SHR  R6 = R7>>field9(0) -> 12
        imem[8]    = 20'h31340; // AND  8&9                -> 8
        imem[9]    = 20'h41340; // OR                      -> 9
        imem[10]   = 20'h51340; // XOR                     -> 1
        imem[11]   = 20'hD20AB; // MOVI R2 = AB
        imem[12]   = 20'hA0207; // STORE R2 data 7, line 7
        imem[13]   = 20'hB0040; // JMP 0x40
        imem[14]   = 20'hD1055; // squashed
        imem[15]   = 20'hD1066; // squashed
        imem[8'h40] = 20'hC0110; // BEQ R1,R1 taken -> 0x10
        imem[8'h41] = 20'hD1077; // squashed
        imem[8'h42] = 20'hD1088; // squashed
        imem[8'h10] = 20'hD30CD; // MOVI R3 = CD
        imem[8'h11] = 20'hE0000; // HALT
        imem[8'h12] = 20'hD1099; // never executes

        tick();
        tick();
        check("rst.imem_addr", {24'd0, imem_addr}, 32'd0);
        check("rst.halted", {31'd0, halted}, 32'd0);
        check("rst.jump_address", {24'd0, jump_address}, 32'd0);
        check_ex("rst", 4'h0, 16'h0, 4'h0, 4'h0, 1'b0);

        rst_n = 1'b1;
        tick(); // E1
        check("E1.imem_addr", {24'd0, imem_addr}, 32'd1);
        tick(); // E2
        tick(); // E3
        check_ex("ADD", 4'h1, 16'd13, 4'h0, 4'h0, 1'b0);
        tick(); check_ex("SUB", 4'h2, 16'd1, 4'h0, 4'h0, 1'b0);
        tick(); check_ex("SUBWRAP", 4'h2, 16'hFFFF, 4'h0, 4'h0, 1'b0);
        tick(); check_ex("LOAD", 4'h9, 16'h0, 4'h3, 4'h5, 1'b0);
        tick(); check_ex("BEQNT", 4'hC, 16'h0, 4'h0, 4'h0, 1'b0);
        check("BEQNT.imem_addr", {24'd0, imem_addr}, 32'd7);
        tick(); check_ex("ADDI", 4'h6, 16'h0105, 4'h4, 4'h0, 1'b0);
        tick(); check_ex("SHL", 4'h7, 16'h0400, 4'h5, 4'h0, 1'b0);
        tick(); check_ex("SHR", 4'h8, 16'd12, 4'h6, 4'h0, 1'b0);
        tick(); check_ex("AND", 4'h3, 16'd8, 4'h1, 4'h0, 1'b0);
        tick(); check_ex("OR", 4'h4, 16'd9, 4'h1, 4'h0, 1'b0);
        tick(); check_ex("XOR", 4'h5, 16'd1, 4'h1, 4'h0, 1'b0);
        tick(); check_ex("MOVI", 4'hD, 16'h00AB, 4'h2, 4'h0, 1'b0);
        tick(); check_ex("STORE", 4'hA, 16'd7, 4'h0, 4'h7, 1'b0);

        tick(); // E16: JMP in EX
        check_ex("JMP", 4'hB, 16'h0, 4'h0, 4'h0, 1'b1);
        check("JMP.jump_address", {24'd0, jump_address}, 32'h40);
        check("JMP.imem_addr", {24'd0, imem_addr}, 32'h40);
        tick(); check_ex("JMPSQ1", 4'h0, 16'h0, 4'h0, 4'h0, 1'b0);
        check("JMPSQ1.imem_addr", {24'd0, imem_addr}, 32'h41);
        tick(); check_ex("JMPSQ2", 4'h0, 16'h0, 4'h0, 4'h0, 1'b0);

        tick(); // E19: BEQ taken
        check_ex("BEQT", 4'hC, 16'h0, 4'h0, 4'h0, 1'b1);
        check("BEQT.jump_address", {24'd0, jump_address}, 32'h10);
        check("BEQT.imem_addr", {24'd0, imem_addr}, 32'h10);
        tick(); check_ex("BEQSQ1", 4'h0, 16'h0, 4'h0, 4'h0, 1'b0);
        tick(); check_ex("BEQSQ2", 4'h0, 16'h0, 4'h0, 4'h0, 1'b0);
        check("preHALT.halted", {31'd0, halted}, 32'd0);

        tick(); // E22: HALT in ID, MOVI completes
        check_ex("MOVICD", 4'hD, 16'h00CD, 4'h3, 4'h0, 1'b0);
        check("HALT.halted", {31'd0, halted}, 32'd1);
        check("HALT.imem_addr", {24'd0, imem_addr}, 32'h12);
        tick(); check_ex("HALTEX", 4'hE, 16'h0, 4'h0, 4'h0, 1'b0);
        check("HALT2.imem_addr", {24'd0, imem_addr}, 32'h12);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_ex("HALTIDLE", 4'h0, 16'h0, 4'h0, 4'h0, 1'b0);
            check("HALTIDLE.imem_addr", {24'd0, imem_addr}, 32'h12);
            check("HALTIDLE.halted", {31'd0, halted}, 32'd1);
        end

        // Asynchronous reset in the middle of a cycle while halted.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.imem_addr", {24'd0, imem_addr}, 32'd0);
        check("arst.halted", {31'd0, halted}, 32'd0);
        check("arst.jump_address", {24'd0, jump_address}, 32'd0);
        check_ex("arst", 4'h0, 16'h0, 4'h0, 4'h0, 1'b0);
        tick();
        check("arst_hold.imem_addr", {24'd0, imem_addr}, 32'd0);

        rst_n = 1'b1;
        tick();
        check("restart.imem_addr", {24'd0, imem_addr}, 32'd1);
        tick();
        tick();
        check_ex("restartADD", 4'h1, 16'd13, 4'h0, 4'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
